// File: rtl/fp_pkg.sv
// Shared FP32 definitions: rounding-mode encoding, exception-flag layout and packed constants.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int          EXP_BIAS  = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_MAXF = 32'h7F7FFFFF;

endpackage

// File: rtl/fadd_norm_round_fp_lzc48.sv
// Combinational 48-bit leading-zero counter; count is 48 and zero_o is set for an all-zero word.
module lzc48 (
  input  logic [47:0] a_i,
  output logic [5:0]  cnt_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    cnt_o = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (a_i[i]) cnt_o = 6'(47 - i);
    end
  end

  assign zero_o = ~|a_i;

endmodule

// File: rtl/fadd_norm_round_fp.sv
// FP32 add/sub back end: normalize, round (RISC-V rm), pack and raise fflags in a 2-stage valid/ready pipe.
// Define FADD_SUBNORMAL_EN for gradual underflow; by default tiny results flush to signed zero.
module fadd_norm_round_fp
  import fp_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MANT_W-1:0]       mantissa_sum,
  input  logic                    carry,
  input  logic                    sign_res,
  input  logic                    sticky_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [2:0]              rm,
  input  logic                    special_valid,
  input  logic [EXP_W+FRAC_W:0]   special_result,
  input  logic [4:0]              special_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [4:0]              fflags
);

  localparam int XW   = EXP_W + 2;
  localparam int KEEP = FRAC_W + 1;
  localparam int GPOS = MANT_W - KEEP - 1;
  localparam int RW   = EXP_W + FRAC_W + 1;

  function automatic logic round_up(input rm_e mode, input logic sign, input logic g,
                                    input logic s, input logic lsb);
    case (mode)
      RNE:     round_up = g & (s | lsb);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (g | s) & sign;
      RUP:     round_up = (g | s) & ~sign;
      RMM:     round_up = g;
      default: round_up = 1'b0;
    endcase
  endfunction

  function automatic logic [RW-1:0] ovf_pack(input rm_e mode, input logic sign);
    logic to_inf;
    to_inf = (mode == RNE) | (mode == RMM) | ((mode == RUP) & ~sign) | ((mode == RDN) & sign);
    if (to_inf) ovf_pack = {sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
    else        ovf_pack = {sign, FP32_MAXF[RW-2:0]};
  endfunction

  logic vld_p1_q, vld_p2_q;
  logic s1_en, s2_en;

  assign s2_en    = ~vld_p2_q | out_ready;
  assign s1_en    = ~vld_p1_q | s2_en;
  assign in_ready = s1_en;

  // Stage 1: normalize via carry right-shift or leading-zero left-shift
  logic [5:0]              lzc;
  logic                    lz_zero;
  logic [MANT_W-1:0]       mant_p1_d;
  logic signed [XW-1:0]    exp_p1_d;
  logic                    sticky_p1_d;

  lzc48 u_lzc (
    .a_i    (mantissa_sum),
    .cnt_o  (lzc),
    .zero_o (lz_zero)
  );

  always_comb begin
    exp_p1_d = $signed({2'b00, exp_in});
    if (carry) begin
      mant_p1_d   = {1'b1, mantissa_sum[MANT_W-1:1]};
      sticky_p1_d = sticky_in | mantissa_sum[0];
      exp_p1_d    = exp_p1_d + XW'(1);
    end else begin
      mant_p1_d   = mantissa_sum << lzc;
      sticky_p1_d = sticky_in;
      exp_p1_d    = exp_p1_d - $signed({{(XW-6){1'b0}}, lzc});
    end
  end

  logic [MANT_W-1:0]    mant_p1_q;
  logic signed [XW-1:0] exp_p1_q;
  logic                 sticky_p1_q, sign_p1_q, zero_p1_q, spec_p1_q;
  rm_e                  rm_p1_q;
  logic [RW-1:0]        sres_p1_q;
  logic [4:0]           sflg_p1_q;

  always_ff @(posedge clk) begin
    if (reset)      vld_p1_q <= 1'b0;
    else if (s1_en) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_en) begin
      mant_p1_q   <= mant_p1_d;
      exp_p1_q    <= exp_p1_d;
      sticky_p1_q <= sticky_p1_d;
      sign_p1_q   <= sign_res;
      zero_p1_q   <= ~carry & lz_zero & ~sticky_in;
      rm_p1_q     <= rm_e'(rm);
      spec_p1_q   <= special_valid;
      sres_p1_q   <= special_result;
      sflg_p1_q   <= special_flags;
    end
  end

  // Stage 2: round, detect overflow/underflow, pack
  logic [MANT_W-1:0]    mant_s;
  logic                 sticky_s, tiny, g, s, inexact, up;
  logic [KEEP:0]        rnd;
  logic signed [XW-1:0] exp_r;
  logic [RW-1:0]        res_p2_d;
  fflags_t              flg_p2_d;
`ifdef FADD_SUBNORMAL_EN
  logic signed [XW-1:0] sh_wide;
  logic [5:0]           sh_amt;
  logic [MANT_W-1:0]    lost;
`endif

  always_comb begin
    res_p2_d = '0;
    flg_p2_d = '0;
    mant_s   = mant_p1_q;
    sticky_s = sticky_p1_q;
    tiny     = (exp_p1_q <= XW'(0));
`ifdef FADD_SUBNORMAL_EN
    sh_wide = XW'(1) - exp_p1_q;
    sh_amt  = (sh_wide > XW'(MANT_W)) ? 6'(MANT_W) : sh_wide[5:0];
    lost    = mant_p1_q & ~({MANT_W{1'b1}} << sh_amt);
    if (tiny) begin
      mant_s   = mant_p1_q >> sh_amt;
      sticky_s = sticky_p1_q | (|lost);
    end
`endif
    g       = mant_s[GPOS];
    s       = (|mant_s[GPOS-1:0]) | sticky_s;
    inexact = g | s;
    up      = round_up(rm_p1_q, sign_p1_q, g, s, mant_s[GPOS+1]);
    rnd     = {1'b0, mant_s[MANT_W-1 -: KEEP]} + {{KEEP{1'b0}}, up};
    exp_r   = exp_p1_q + $signed({{(XW-1){1'b0}}, rnd[KEEP]});

    if (spec_p1_q) begin
      res_p2_d = sres_p1_q;
      flg_p2_d = fflags_t'(sflg_p1_q);
    end else if (zero_p1_q) begin
      // Exact cancellation: -0 only when rounding down.
      res_p2_d = {(rm_p1_q == RDN), {(RW-1){1'b0}}};
    end else if (tiny) begin
`ifdef FADD_SUBNORMAL_EN
      // Rounding up into bit 23 lands on the minimum normal (exp field 1).
      res_p2_d    = {sign_p1_q, {(EXP_W-1){1'b0}}, rnd[KEEP-1], rnd[FRAC_W-1:0]};
      flg_p2_d.uf = inexact;
      flg_p2_d.nx = inexact;
`else
      res_p2_d    = {sign_p1_q, {(RW-1){1'b0}}};
      flg_p2_d.uf = 1'b1;
      flg_p2_d.nx = 1'b1;
`endif
    end else if (exp_r >= XW'(EXP_MAX)) begin
      res_p2_d    = ovf_pack(rm_p1_q, sign_p1_q);
      flg_p2_d.of = 1'b1;
      flg_p2_d.nx = 1'b1;
    end else begin
      res_p2_d    = {sign_p1_q, exp_r[EXP_W-1:0],
                     rnd[KEEP] ? rnd[KEEP-1:1] : rnd[FRAC_W-1:0]};
      flg_p2_d.nx = inexact;
    end
  end

  logic [RW-1:0] res_p2_q;
  fflags_t       flg_p2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      flg_p2_q <= '0;
    end else if (s2_en) begin
      vld_p2_q <= vld_p1_q;
      res_p2_q <= res_p2_d;
      flg_p2_q <= flg_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = res_p2_q;
  assign fflags    = flg_p2_q;

endmodule

// File: tb/tb_fadd_norm_round_fp.sv
// Scoreboard bench for fadd_norm_round_fp: directed corner cases plus randomized beats against a value-level model.
module tb_fadd_norm_round_fp;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] mantissa_sum = '0;
  logic        carry = 1'b0;
  logic        sign_res = 1'b0;
  logic        sticky_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [2:0]  rm = '0;
  logic        special_valid = 1'b0;
  logic [31:0] special_result = '0;
  logic [4:0]  special_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  fflags;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   stall = 1'b0;
  bit   rand_ready = 1'b0;

  fadd_norm_round_fp dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mantissa_sum(mantissa_sum), .carry(carry), .sign_res(sign_res), .sticky_in(sticky_in),
    .exp_in(exp_in), .rm(rm), .special_valid(special_valid), .special_result(special_result),
    .special_flags(special_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .fflags(fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Value-level reference: treat {carry,sum} as an integer significand scaled by 2^(exp-127-47).
  function automatic exp_t model(input logic [47:0] sum, input logic c, input logic sg, input logic st,
                                 input logic [7:0] ein, input logic [2:0] rmv, input logic sv,
                                 input logic [31:0] sr, input logic [4:0] sf);
    exp_t r;
    longint unsigned full, q, mask;
    int p, e, drop;
    bit g, s, inc, sub;
    r.res = sr;
    r.fl  = sf;
    if (sv) return r;
    full = {15'b0, c, sum};
    if (full == 0) begin
      r.res = (rmv == 3'd2) ? 32'h80000000 : 32'h00000000;
      r.fl  = 5'b0;
      return r;
    end
    p = 0;
    for (int i = 0; i < 49; i++) if (full[i]) p = i;
    e    = int'(ein) + p - 47;
    sub  = 1'b0;
    drop = p - 23;
    if (e <= 0) begin
`ifdef FADD_SUBNORMAL_EN
      sub  = 1'b1;
      drop = drop + 1 - e;
`else
      r.res = {sg, 31'b0};
      r.fl  = 5'b00011;
      return r;
`endif
    end
    if (drop <= 0) begin
      q = full << (-drop); g = 1'b0; s = st;
    end else if (drop > 60) begin
      q = 0; g = 1'b0; s = 1'b1;
    end else begin
      q    = full >> drop;
      g    = full[drop-1];
      mask = (64'd1 << (drop - 1)) - 64'd1;
      s    = ((full & mask) != 0) || st;
    end
    case (rmv)
      3'd0:    inc = g && (s || q[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = (g || s) && sg;
      3'd3:    inc = (g || s) && !sg;
      default: inc = g;
    endcase
    q = q + 64'(inc);
    if (sub) begin
      r.res = {sg, 7'd0, q[23], q[22:0]};
      r.fl  = {3'b0, g | s, g | s};
      return r;
    end
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
    if (e >= 255) begin
      if (rmv == 3'd0 || rmv == 3'd4 || (rmv == 3'd3 && !sg) || (rmv == 3'd2 && sg))
        r.res = {sg, 31'h7F800000};
      else
        r.res = {sg, 31'h7F7FFFFF};
      r.fl = 5'b00101;
    end else begin
      r.res = {sg, e[7:0], q[22:0]};
      r.fl  = {4'b0, g | s};
    end
    return r;
  endfunction

  task automatic drive(input logic [47:0] sm, input logic c, input logic sg, input logic st,
                       input logic [7:0] ein, input logic [2:0] rmv, input logic sv,
                       input logic [31:0] sr, input logic [4:0] sf);
    mantissa_sum = sm; carry = c; sign_res = sg; sticky_in = st; exp_in = ein; rm = rmv;
    special_valid = sv; special_result = sr; special_flags = sf;
  endtask

  task automatic send(input logic [47:0] sm, input logic c, input logic sg, input logic st,
                      input logic [7:0] ein, input logic [2:0] rmv, input logic sv,
                      input logic [31:0] sr, input logic [4:0] sf,
                      input bit dir, input logic [31:0] dres, input logic [4:0] dfl);
    exp_t e;
    @(negedge clk);
    drive(sm, c, sg, st, ein, rmv, sv, sr, sf);
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      #4;
      if (in_ready) break;
      if (t > 500) begin
        $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
        $fatal(1, "input handshake never completed");
      end
      @(negedge clk);
    end
    if (dir) begin e.res = dres; e.fl = dfl; end
    else e = model(sm, c, sg, st, ein, rmv, sv, sr, sf);
    sb.push_back(e);
    n_vec++;
    @(posedge clk);
  endtask

  task automatic send_rand();
    logic [63:0] r64;
    logic [47:0] sm;
    logic c, sg, st, sv;
    logic [7:0] ein;
    logic [2:0] rmv;
    logic [31:0] sr;
    logic [4:0] sf;
    r64 = {$urandom(), $urandom()};
    sm  = r64[47:0];
    if ($urandom_range(0, 1) == 1) sm = sm >> $urandom_range(0, 47);
    if ($urandom_range(0, 19) == 0) sm = '0;
    c  = ($urandom_range(0, 3) == 0);
    st = (c | (|sm)) ? ($urandom_range(0, 3) == 0) : 1'b0;
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       ein = 8'($urandom_range(1, 40));
      1:       ein = 8'($urandom_range(248, 254));
      default: ein = 8'($urandom_range(1, 254));
    endcase
    rmv = 3'($urandom_range(0, 4));
    sv  = ($urandom_range(0, 9) == 0);
    sr  = $urandom();
    sf  = 5'($urandom_range(0, 31));
    send(sm, c, sg, st, ein, rmv, sv, sr, sf, 1'b0, 32'h0, 5'h0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares every presented output with the scoreboard head, pops on handshake.
  initial begin : monitor
    bit   hold;
    exp_t e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en)         out_ready = 1'b1;
      else if (stall)      out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b1;
      #4;
      if (reset || !mon_en) begin
        hold = 1'b0;
      end else begin
        if (hold) chk("hold_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            miscompares++;
            $display("FAIL unexpected_output: got result %h, expected no output", result);
          end else begin
            e = sb[0];
            chk("result", result, e.res);
            chk("fflags", 32'(fflags), 32'(e.fl));
            if (out_ready) void'(sb.pop_front());
          end
        end
        hold = out_valid && !out_ready;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #4;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 1.0 latency
    @(negedge clk);
    drive(48'h0, 1'b1, 1'b0, 1'b0, 8'd127, 3'd0, 1'b0, 32'h0, 5'h0);
    in_valid = 1'b1;
    #4 chk("lat_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #4 chk("lat_cyc1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #4;
    chk("lat_cyc2_valid", 32'(out_valid), 32'd1);
    chk("lat_result", result, 32'h40000000);
    chk("lat_fflags", 32'(fflags), 32'd0);
    @(negedge clk);
    #4 chk("lat_cyc3_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Directed corner cases
    send(48'h0, 0, 0, 0, 8'd127, 3'd2, 0, 32'h0, 5'h0, 1, 32'h80000000, 5'h00);
    send(48'h0, 0, 0, 0, 8'd127, 3'd0, 0, 32'h0, 5'h0, 1, 32'h00000000, 5'h00);
    send(48'h800001_800000, 0, 0, 0, 8'd127, 3'd0, 0, 32'h0, 5'h0, 1, 32'h3F800002, 5'h01);
    send(48'h0, 1, 0, 0, 8'd254, 3'd0, 0, 32'h0, 5'h0, 1, 32'h7F800000, 5'h05);
    send(48'h0, 1, 0, 0, 8'd254, 3'd1, 0, 32'h0, 5'h0, 1, 32'h7F7FFFFF, 5'h05);
    send(48'h0, 1, 1, 0, 8'd254, 3'd2, 0, 32'h0, 5'h0, 1, 32'hFF800000, 5'h05);
    send(48'h0, 1, 0, 0, 8'd254, 3'd2, 0, 32'h0, 5'h0, 1, 32'h7F7FFFFF, 5'h05);
    send(48'hC00000_000000, 0, 0, 0, 8'd127, 3'd0, 0, 32'h0, 5'h0, 1, 32'h3FC00000, 5'h00);
    send(48'hFFFFFF_000001, 0, 0, 0, 8'd127, 3'd3, 0, 32'h0, 5'h0, 1, 32'h40000000, 5'h01);
    send(48'h123456_789ABC, 1, 0, 1, 8'd100, 3'd0, 1, 32'h7FC00000, 5'h10, 1, 32'h7FC00000, 5'h10);
`ifdef FADD_SUBNORMAL_EN
    send(48'h400000_000000, 0, 1, 0, 8'd1, 3'd0, 0, 32'h0, 5'h0, 1, 32'h80400000, 5'h00);
`else
    send(48'h400000_000000, 0, 1, 0, 8'd1, 3'd0, 0, 32'h0, 5'h0, 1, 32'h80000000, 5'h03);
`endif
    idle();
    drain();

    // Backpressure: two beats fill the pipe, the rest wait for out_ready
    @(posedge clk);
    #1 stall = 1'b1;
    send_rand();
    send_rand();
    fork
      begin
        send_rand();
        send_rand();
      end
      begin
        @(negedge clk);
        #4 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    idle();
    drain();

    // Randomized traffic with random downstream backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_rand();
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    drain();
    rand_ready = 1'b0;

    // Reset with both stages occupied
    @(posedge clk);
    #1 stall = 1'b1;
    send_rand();
    send_rand();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #4;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 stall = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
